pipe_perf_counter: RTL and testbench
====================================

// Module: pipe_perf_counter
// PURPOSE
//   Producer side of the CPU cycle/instruction statistics the testbench prints.
//   Sits inside PipeCPU beside the WB stage. Counts cycles, retired instructions,
//   stall cycles and flushes; drives n_cycle/n_exe_instr continuously; serves
//   snapshot reads over a req/valid port. Freezes on program halt.
// PARAMETERS
//   W        32   counter width in bits (n_cycle/n_exe_instr ports are W wide)
// PORTS
//   clk          in   1   clock, all logic on rising edge
//   n_rst        in   1   reset, synchronous, active-high (name kept from codebase)
//   run_en       in   1   start counting (level; sampled in IDLE)
//   clear        in   1   synchronous zero of all counters, return to IDLE
//   retire_valid in   1   WB stage retires a valid (non-bubble) instruction this cycle
//   stall        in   1   pipeline stalled this cycle (load-use / hazard)
//   flush        in   1   branch/jump flush this cycle
//   halt         in   1   halting instruction retired (ebreak/ecall)
//   rd_req       in   1   snapshot read request, one-cycle pulse
//   rd_sel       in   2   0=cycle 1=instr 2=stall 3=flush
//   rd_valid     out  1   read data valid, one-cycle pulse
//   rd_data      out  W   selected counter value
//   n_cycle      out  W   live cycle count
//   n_exe_instr  out  W   live retired-instruction count
//   halted       out  1   high in HALTED state
//   ovf          out  1   sticky: any counter hit max
// BEHAVIOUR
//   Reset: state=IDLE; all counters, rd_valid, rd_data, halted, ovf = 0.
//   FSM: IDLE -(run_en)-> COUNT -(halt)-> HALTED; clear from any state -> IDLE.
//     reset/clear priority: n_rst > clear > everything else.
//   IDLE: nothing counts. Cycle of run_en=1 in IDLE is not counted; counting
//     starts the following cycle.
//   COUNT, per cycle: cyc+=1; instr+=retire_valid; stall_c+=stall; flush_c+=flush.
//     Events are independent: retire/stall/flush all high -> all three increment.
//   halt in COUNT: that cycle still counted (incl. its retire); next state HALTED.
//   HALTED: counters frozen, halted=1; retire/stall/flush/halt ignored; leaves
//     only via clear or n_rst.
//   Outputs n_cycle/n_exe_instr are registers (no comb path from inputs).
//   Read: rd_req in cycle t -> rd_valid=1, rd_data=value of rd_sel counter as
//     registered at end of cycle t-1 (pre-update value), in cycle t+1.
//     Back-to-back requests allowed, one response per request, no ordering stalls.
//     Reads honoured in every state; rd_req coincident with clear returns the
//     pre-clear value. rd_data holds last value when rd_valid=0.
//   Arithmetic: unsigned W-bit. Wrap vs saturate set by macro below.
//   ovf sets when any increment would exceed 2^W-1; cleared only by clear/n_rst.
// CONFIGURATION
//   PERF_SATURATE_EN defined: counters stick at 2^W-1, ovf set.
//   Not defined: counters wrap to 0 modulo 2^W, ovf still set on the wrap.
// TESTING
//   1 reset 3 cycles, run_en=0 10 cycles -> n_cycle=0, n_exe_instr=0, halted=0.
//   2 run_en then 20 cycles, retire_valid every 2nd cycle -> n_cycle=20, n_exe_instr=10.
//   3 retire+stall+flush high same cycle x5 -> instr, stall_c, flush_c each +5.
//   4 halt at cycle 8 with retire -> n_cycle=8, instr includes it, halted=1, frozen
//     for 50 more cycles; clear -> all 0, IDLE.
//   5 rd_req sel=1 at t, sel=3 at t+1 -> rd_valid at t+1,t+2 with pre-update values.
//   6 W=4, 20 counted cycles -> SATURATE_EN: n_cycle=15, ovf=1; else n_cycle=4, ovf=1.

Source files
------------

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: cycle/retire/stall/flush counters with snapshot reads, frozen on halt; PERF_SATURATE_EN makes counters saturate instead of wrap
module pipe_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         run_en,
  input  logic         clear,
  input  logic         retire_valid,
  input  logic         stall,
  input  logic         flush,
  input  logic         halt,
  input  logic         rd_req,
  input  logic [1:0]   rd_sel,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] n_cycle,
  output logic [W-1:0] n_exe_instr,
  output logic         halted,
  output logic         ovf
);
  typedef enum logic [1:0] {IDLE, COUNT, HALTED} state_t;
  state_t state;
  logic [W-1:0] stall_c, flush_c, cyc_nx, ins_nx, stl_nx, fls_nx;
  logic o_c, o_i, o_s, o_f;
  function automatic logic [W:0] bump(input logic [W-1:0] v, input logic en);
    logic top;
    top = en & (&v);
`ifdef PERF_SATURATE_EN
    return {top, top ? v : v + W'(en)};
`else
    return {top, v + W'(en)};
`endif
  endfunction
  always_comb begin
    {o_c, cyc_nx} = bump(n_cycle, 1'b1);
    {o_i, ins_nx} = bump(n_exe_instr, retire_valid);
    {o_s, stl_nx} = bump(stall_c, stall);
    {o_f, fls_nx} = bump(flush_c, flush);
  end
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state       <= IDLE;
      n_cycle     <= '0;
      n_exe_instr <= '0;
      stall_c     <= '0;
      flush_c     <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      halted      <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)
        rd_data <= rd_sel == 2'd0 ? n_cycle : rd_sel == 2'd1 ? n_exe_instr : rd_sel == 2'd2 ? stall_c : flush_c;
      if (clear) begin
        state       <= IDLE;
        n_cycle     <= '0;
        n_exe_instr <= '0;
        stall_c     <= '0;
        flush_c     <= '0;
        halted      <= 1'b0;
        ovf         <= 1'b0;
      end else if (state == IDLE) begin
        if (run_en) state <= COUNT;
      end else if (state == COUNT) begin
        n_cycle     <= cyc_nx;
        n_exe_instr <= ins_nx;
        stall_c     <= stl_nx;
        flush_c     <= fls_nx;
        ovf         <= ovf | o_c | o_i | o_s | o_f;
        if (halt) begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_perf_counter.sv
// tb_pipe_perf_counter: scoreboard bench for pipe_perf_counter at W=32 plus a W=4 instance for overflow
module tb_pipe_perf_counter;
  logic clk = 1'b0;
  logic n_rst, run_en, clear, retire_valid, stall, flush, halt, rd_req;
  logic [1:0] rd_sel;
  logic rd_valid, halted, ovf, s_rd_valid, s_halted, s_ovf;
  logic [31:0] rd_data, n_cycle, n_exe_instr;
  logic [3:0] s_rd_data, s_cycle, s_instr;
  int vectors = 0, miscompares = 0;
  int unsigned m_cyc, m_ins, m_stl, m_fls, m_st;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  pipe_perf_counter #(.W(32)) dut (
    .clk(clk), .n_rst(n_rst), .run_en(run_en), .clear(clear), .retire_valid(retire_valid),
    .stall(stall), .flush(flush), .halt(halt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .n_cycle(n_cycle), .n_exe_instr(n_exe_instr),
    .halted(halted), .ovf(ovf)
  );
  pipe_perf_counter #(.W(4)) dut_s (
    .clk(clk), .n_rst(n_rst), .run_en(run_en), .clear(clear), .retire_valid(retire_valid),
    .stall(stall), .flush(flush), .halt(halt), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .n_cycle(s_cycle), .n_exe_instr(s_instr),
    .halted(s_halted), .ovf(s_ovf)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic re, st, fl, hl, en, clr, rq, input logic [1:0] sel);
    logic [31:0] v;
    {retire_valid, stall, flush, halt, run_en, clear, rd_req, rd_sel} = {re, st, fl, hl, en, clr, rq, sel};
    if (rq) sb.push_back(sel == 2'd0 ? m_cyc : sel == 2'd1 ? m_ins : sel == 2'd2 ? m_stl : m_fls);
    if (clr) begin
      {m_cyc, m_ins, m_stl, m_fls, m_st} = '0;
    end else if (m_st == 0) begin
      if (en) m_st = 1;
    end else if (m_st == 1) begin
      m_cyc++;
      m_ins += 32'(re);
      m_stl += 32'(st);
      m_fls += 32'(fl);
      if (hl) m_st = 2;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, rq);
    chk("s_rd_valid", s_rd_valid, rq);
    if (sb.size() > 0) begin
      v = sb.pop_front();
      if (rd_valid) chk("rd_data", rd_data, v);
    end
    {retire_valid, stall, flush, halt, run_en, clear, rd_req, rd_sel} = '0;
  endtask
  task automatic chk_live(input string tag);
    chk({tag, "_cyc"}, n_cycle, m_cyc);
    chk({tag, "_instr"}, n_exe_instr, m_ins);
    chk({tag, "_halted"}, halted, m_st == 2);
  endtask
  initial begin
    int unsigned exp_s;
    {retire_valid, stall, flush, halt, run_en, clear, rd_req, rd_sel} = '0;
    {m_cyc, m_ins, m_stl, m_fls, m_st} = '0;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b0;
    chk("rst_cyc", n_cycle, 0);
    chk("rst_instr", n_exe_instr, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ovf", ovf, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
    chk_live("idle");
    chk("idle_cyc0", n_cycle, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(i % 2 == 1, i % 3 == 0, i % 5 == 0, 0, 0, 0, i % 4 == 0, 2'(i / 4));
    chk_live("run");
    chk("run_cyc20", n_cycle, 20);
    chk("run_instr10", n_exe_instr, 10);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) step(0, 0, 0, 0, 0, 0, 1, 2'(s));
    chk_live("all3");
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) step(k == 3 || k == 8, 0, 0, k == 8, 0, 0, 0, 0);
    chk_live("halt");
    chk("halt_cyc8", n_cycle, 8);
    chk("halt_instr2", n_exe_instr, 2);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 50; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 1'($urandom), 2'($urandom));
    chk_live("frozen");
    chk("frozen_cyc8", n_cycle, 8);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    chk_live("clr");
    chk("clr_halted", halted, 0);
    chk("clr_ovf", ovf, 0);
    chk("clr_s_ovf", s_ovf, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_hold", rd_data, 4);
    chk_live("b2b");
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PERF_SATURATE_EN
    exp_s = 15;
`else
    exp_s = 4;
`endif
    chk("w4_cyc", s_cycle, exp_s);
    chk("w4_instr", s_instr, exp_s);
    chk("w4_ovf", s_ovf, 1);
    chk("w32_ovf", ovf, 0);
    chk("w32_cyc20", n_cycle, 20);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("w4_rd_data", s_rd_data, exp_s);
    chk("w4_halted", s_halted, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
